// File: rtl/tsbus_arb_pkg.sv
// rtl/tsbus_arb_pkg.sv - shared types and helpers for the tri-state bus arbiter
package tsbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // Index width for a requester vector, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after the last owner
module rr_pick
    import tsbus_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            any,
    output logic [IW-1:0]   winner
);

    logic          hi_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IW'(j);
                if (IW'(j) > last) begin
                    hi_idx   = IW'(j);
                    hi_found = 1'b1;
                end
            end
        end
        any    = |req;
        winner = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner of tri-state driver enables with dead-time
module tristate_bus_arbiter
    import tsbus_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           en,
    output logic [id_width(NREQ)-1:0] gnt_id,
    output logic                      busy
);

    localparam int            IW        = id_width(NREQ);
    localparam int            HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [3:0]    TURN_LAST = 4'(TURN_CYC - 1);
    localparam bit            PREEMPT   = (MAX_HOLD != 0);

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0] en_q, en_d;
    logic            busy_q, busy_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [3:0]      turn_q, turn_d;
    logic            pick_any;
    logic [IW-1:0]   pick_winner;
    logic            grant;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) grant = 1'b1;
            end
            ST_OWN: begin
                if (hold_q != '1) hold_d = hold_q + 1'b1;
                // >= rather than == so a requester arriving after the hold window still preempts.
                if (!req[gnt_q] || (PREEMPT && (hold_q >= HOLD_LAST) && |(req & ~en_q))) begin
                    state_d = ST_TURN;
                    en_d    = '0;
                    turn_d  = '0;
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    if (pick_any) begin
                        grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            state_d             = ST_OWN;
            last_d              = pick_winner;
            gnt_d               = pick_winner;
            en_d                = '0;
            en_d[pick_winner]   = 1'b1;
            busy_d              = 1'b1;
            hold_d              = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NREQ - 1);
            gnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign en     = en_q;
    assign gnt_id = gnt_q;
    assign busy   = busy_q;

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that owns the output-enable lines of NREQ tri-state drivers sharing one net (the gated AND/OR-driver pattern with per-driver enables). It guarantees at most one enable is high at any time and inserts a programmable dead-time between owners, so a driver's disable delay never overlaps the next driver's enable. It sits between requesting logic and the tri-state gate enables. All enables are registered.

## Interface
- NREQ, 2, number of requesters/drivers (2..8)
- TURN_CYC, 1, dead-time cycles with all enables low between owners (1..15)
- MAX_HOLD, 8, maximum consecutive owner cycles while another request is pending; 0 = unlimited
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per driver; held high for as long as the bus is wanted
- en  output  NREQ  registered driver enables; one-hot or all-zero
- gnt_id  output  $clog2(NREQ)  index of current owner; valid only while en != 0
- busy  output  1  high in OWN or TURN

## Operation
- Reset values: en=0, gnt_id=0, busy=0, state=IDLE, priority pointer last=NREQ-1 (req[0] wins first), hold_cnt=0, turn_cnt=0.
- States: IDLE (en=0), OWN (en[owner]=1), TURN (en=0, dead-time).
- IDLE: if any req sampled high, pick winner -> OWN next cycle; else stay.
- Winner: first asserted req searching from last+1 upward with wrap-around; on grant, last := winner.
- OWN: hold_cnt increments each cycle, saturating. Leave to TURN when req[owner]=0, or when MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and any other req is high (preemption). Otherwise stay.
- TURN: exactly TURN_CYC cycles with en=0. On the last TURN cycle sample req: any high -> OWN with new winner; none -> IDLE.
- A preempted owner still holding req competes normally; round-robin places it last.
- The previous owner may win again after TURN if it is the only requester. TURN is still inserted.
- IDLE is entered only from reset or TURN, so IDLE->OWN needs no dead-time.
- Invariant: popcount(en) <= 1 every cycle. No two different owners in adjacent cycles.

## Timing
- Grant latency from IDLE: req sampled at edge N -> en high after edge N+1 (1 cycle).
- Release: req[owner] low sampled at edge N -> en=0 from edge N+1. Next owner's en rises at edge N+1+TURN_CYC.
- Example, TURN_CYC=1: req=01 at cycle 0 -> en=01 at cycle 1. req=10 at cycle 4 -> en=00 at cycle 5, en=10 at cycle 6.
- Preemption, MAX_HOLD=M: owner has en for exactly M cycles, then TURN_CYC idle cycles, then the other requester.
- Simultaneous requests in IDLE: pointer decides; no starvation. Every pending requester is granted within NREQ*(MAX_HOLD+TURN_CYC) cycles when MAX_HOLD!=0.
- req dropping and re-rising during TURN is only sampled on the last TURN cycle.
- Reset mid-operation: at the next rising edge en=0 and all state returns to reset values. Dead-time across reset is not guaranteed; the driver side must tolerate this.
- gnt_id changes only in the cycle en goes nonzero. It keeps its last value while en=0.

## Structure
- Shared package tsbus_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_TURN=2'd2
  - width helper for gnt_id
- Sub-module rr_pick: combinational; inputs req and last; outputs any and winner. The top instantiates it once.
- Top holds the FSM, hold_cnt (width from MAX_HOLD), turn_cnt (4 bits), pointer and output registers.

## Test plan
- Reset then single request: rst 2 cycles, req=01 -> en=01 exactly 1 cycle later, busy=1, gnt_id=0; drop req -> en=00, then IDLE after TURN_CYC.
- Simultaneous requests, NREQ=2: req=11 from IDLE -> en=01 first. Release -> TURN_CYC zero cycles, then en=10, gnt_id=1.
- Preemption, MAX_HOLD=4, TURN_CYC=2: req=11 held -> en alternates 01 x4, 00 x2, 10 x4, 00 x2, repeating.
- NREQ=4 wrap-around: last owner 3, req=1010 -> next grant index 1, then 3.
- Reset mid-OWN: assert rst while en=10 -> en=00, busy=0 at next edge; after release req=11 -> en=01.
- Invariant check over random req, 10k cycles: popcount(en)<=1 always; owner changes separated by >= TURN_CYC zero-enable cycles.
